// File: rtl/seg_display_capture.sv
// -----------------------------------------------------------------------------
// seg_display_capture
//
// Receive side of the calculator's 4-digit multiplexed 7-segment display.
// Watches the 14 segment lines and the two digit-pair strobes, waits for each
// strobe phase to be held stable, then rebuilds the 10-bit displayed value.
//
// Ports
//   clk          in   1   system clock
//   rst_n        in   1   synchronous reset, active low
//   seg_in       in   14  [13:7] high digit of pair, [6:0] low digit; {g,f,e,d,c,b,a}
//   power13      in   1   digits 1 (thousands) and 3 (tens) enabled
//   power24      in   1   digits 2 (hundreds) and 4 (ones) enabled
//   value        out  10  last good decoded value, held between frames
//   value_valid  out  1   pulse: new frame decoded, value updated
//   dash_err     out  1   pulse: all four digits showed a dash
//   code_err     out  1   pulse: illegal pattern, mixed dash/digit, or value > 1023
//   timeout      out  1   pulse: phase B not accepted in time after phase A
//   state_dbg    out  2   FSM state (0 IDLE, 1 WAIT_B, 2 EVAL)
//
// Handshake: there is no back-pressure. Each result pulse is a single-cycle
// strobe; at most one of value_valid/dash_err/code_err/timeout is high in any
// cycle, and value is only meaningful (and only changes) with value_valid.
// -----------------------------------------------------------------------------
module seg_display_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] seg_in,
  input  logic        power13,
  input  logic        power24,
  output logic [9:0]  value,
  output logic        value_valid,
  output logic        dash_err,
  output logic        code_err,
  output logic        timeout,
  output logic [1:0]  state_dbg
);

  // stab_cnt saturates one above STABLE_CYCLES so the accept condition
  // (count == STABLE_CYCLES) is true for exactly one cycle per hold.
  localparam int SW = $clog2(STABLE_CYCLES + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STABLE_V  = SW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    PH_BLANK = 2'd0,
    PH_A     = 2'd1,
    PH_B     = 2'd2
  } phase_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT_B = 2'd1,
    S_EVAL   = 2'd2
  } state_t;

  phase_t        phase_in;
  phase_t        phase_s, phase_p;
  logic [13:0]   seg_s, seg_p;
  logic [SW-1:0] stab_cnt;
  logic          accept_a, accept_b;

  state_t        state, state_n;
  logic [6:0]    d1, d2, d3, d4;
  logic [TW-1:0] tcnt;
  logic          latch_a, latch_b, tcnt_clr, tcnt_inc;
  logic          vv_n, de_n, ce_n, to_n;
  logic [9:0]    value_n;

  logic [5:0]    c1, c2, c3, c4;
  logic          all_dash, any_dash, any_ill;
  logic [13:0]   sum;

  // Returns {illegal, dash, digit[3:0]}. A fully dark digit is a suppressed
  // leading zero and decodes as 0.
  function automatic logic [5:0] decode_seg(input logic [6:0] s);
    logic [5:0] r;
    case (s)
      7'b0111111: r = {2'b00, 4'd0};
      7'b0000110: r = {2'b00, 4'd1};
      7'b1011011: r = {2'b00, 4'd2};
      7'b1001111: r = {2'b00, 4'd3};
      7'b1100110: r = {2'b00, 4'd4};
      7'b1101101: r = {2'b00, 4'd5};
      7'b1111101: r = {2'b00, 4'd6};
      7'b0000111: r = {2'b00, 4'd7};
      7'b1111111: r = {2'b00, 4'd8};
      7'b1101111: r = {2'b00, 4'd9};
      7'b0000000: r = {2'b00, 4'd0};
      7'b1000000: r = {2'b01, 4'd0};
      default:    r = {2'b10, 4'd0};
    endcase
    return r;
  endfunction

  always_comb begin
    case ({power13, power24})
      2'b10:   phase_in = PH_A;
      2'b01:   phase_in = PH_B;
      default: phase_in = PH_BLANK;
    endcase
  end

  // Two sample stages: seg_s/phase_s is the current sample, seg_p/phase_p the
  // previous one. When the count reaches STABLE_CYCLES, seg_p holds the
  // sample that completed the hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_s    <= '0;
      seg_p    <= '0;
      phase_s  <= PH_BLANK;
      phase_p  <= PH_BLANK;
      stab_cnt <= '0;
    end else begin
      seg_s   <= seg_in;
      phase_s <= phase_in;
      seg_p   <= seg_s;
      phase_p <= phase_s;
      if (phase_s == PH_BLANK || phase_s != phase_p || seg_s != seg_p)
        stab_cnt <= SW'(1);
      else if (stab_cnt <= STABLE_V)
        stab_cnt <= stab_cnt + SW'(1);
    end
  end

  assign accept_a = (stab_cnt == STABLE_V) && (phase_p == PH_A);
  assign accept_b = (stab_cnt == STABLE_V) && (phase_p == PH_B);

  // Frame evaluation, only consumed in S_EVAL.
  always_comb begin
    c1       = decode_seg(d1);
    c2       = decode_seg(d2);
    c3       = decode_seg(d3);
    c4       = decode_seg(d4);
    all_dash = c1[4] & c2[4] & c3[4] & c4[4];
    any_dash = c1[4] | c2[4] | c3[4] | c4[4];
    any_ill  = c1[5] | c2[5] | c3[5] | c4[5];
    sum      = 14'(c1[3:0]) * 14'd1000 + 14'(c2[3:0]) * 14'd100
             + 14'(c3[3:0]) * 14'd10   + 14'(c4[3:0]);
  end

  always_comb begin
    state_n  = state;
    latch_a  = 1'b0;
    latch_b  = 1'b0;
    tcnt_clr = 1'b0;
    tcnt_inc = 1'b0;
    vv_n     = 1'b0;
    de_n     = 1'b0;
    ce_n     = 1'b0;
    to_n     = 1'b0;
    value_n  = value;
    case (state)
      S_IDLE: begin
        if (accept_a) begin
          latch_a  = 1'b1;
          tcnt_clr = 1'b1;
          state_n  = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (accept_b) begin
          latch_b  = 1'b1;
          tcnt_clr = 1'b1;
          state_n  = S_EVAL;
        end else if (accept_a) begin
          // A fresh A hold replaces d1/d3 and restarts the window.
          latch_a  = 1'b1;
          tcnt_clr = 1'b1;
        end else if (tcnt >= TOUT_LAST) begin
          to_n     = 1'b1;
          tcnt_clr = 1'b1;
          state_n  = S_IDLE;
        end else begin
          tcnt_inc = 1'b1;
        end
      end
      S_EVAL: begin
        state_n = S_IDLE;
        if (all_dash) begin
          de_n = 1'b1;
        end else if (any_ill || any_dash) begin
          ce_n = 1'b1;
        end else if (sum > 14'd1023) begin
          ce_n = 1'b1;
        end else begin
          vv_n    = 1'b1;
          value_n = sum[9:0];
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value       <= '0;
      value_valid <= 1'b0;
      dash_err    <= 1'b0;
      code_err    <= 1'b0;
      timeout     <= 1'b0;
      d1          <= '0;
      d2          <= '0;
      d3          <= '0;
      d4          <= '0;
      tcnt        <= '0;
    end else begin
      value       <= value_n;
      value_valid <= vv_n;
      dash_err    <= de_n;
      code_err    <= ce_n;
      timeout     <= to_n;
      if (latch_a) begin
        d1 <= seg_p[13:7];
        d3 <= seg_p[6:0];
      end
      if (latch_b) begin
        d2 <= seg_p[13:7];
        d4 <= seg_p[6:0];
      end
      if (tcnt_clr)
        tcnt <= '0;
      else if (tcnt_inc && tcnt != TOUT_LAST)
        tcnt <= tcnt + TW'(1);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_seg_display_capture.sv
module tb_seg_display_capture;

  localparam int STABLE = 4;
  localparam int TOUT   = 64;

  localparam logic [1:0] PH_BL = 2'd0;
  localparam logic [1:0] PH_A  = 2'd1;
  localparam logic [1:0] PH_B  = 2'd2;

  localparam logic [2:0] K_VALID = 3'd1;
  localparam logic [2:0] K_DASH  = 3'd2;
  localparam logic [2:0] K_CODE  = 3'd3;
  localparam logic [2:0] K_TOUT  = 3'd4;

  localparam logic [6:0] DASH = 7'b1000000;
  localparam logic [6:0] DARK = 7'b0000000;
  localparam logic [6:0] ILL  = 7'b1010101;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] seg_in;
  logic        power13, power24;
  logic [9:0]  value;
  logic        value_valid, dash_err, code_err, timeout;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  seg_display_capture #(
    .STABLE_CYCLES (STABLE),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .power13    (power13),
    .power24    (power24),
    .value      (value),
    .value_valid(value_valid),
    .dash_err   (dash_err),
    .code_err   (code_err),
    .timeout    (timeout),
    .state_dbg  (state_dbg)
  );

  logic [6:0] seg_tab [0:9];
  int n_cmp = 0;
  int n_err = 0;
  logic [12:0] exp_q[$];
  logic [9:0]  last_good = 10'd0;

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (value_valid | dash_err | code_err | timeout)) begin
      logic [2:0]  kind;
      logic [12:0] obs, expv;
      int          npulse;
      npulse = int'(value_valid) + int'(dash_err) + int'(code_err) + int'(timeout);
      n_cmp++;
      if (npulse != 1) begin
        n_err++;
        $display("FAIL overlap: got %0d simultaneous pulses, required 1", npulse);
      end
      kind = value_valid ? K_VALID : dash_err ? K_DASH : code_err ? K_CODE : K_TOUT;
      obs  = {kind, value};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: got kind=%0d value=%0d, required no pulse", kind, value);
      end else begin
        expv = exp_q.pop_front();
        if (obs !== expv) begin
          n_err++;
          $display("FAIL pulse: got kind=%0d value=%0d, required kind=%0d value=%0d",
                   obs[12:10], obs[9:0], expv[12:10], expv[9:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic hold(input logic [1:0] ph, input logic [6:0] hi, input logic [6:0] lo,
                      input int n);
    @(negedge clk);
    power13 = (ph == PH_A);
    power24 = (ph == PH_B);
    seg_in  = {hi, lo};
    repeat (n) @(posedge clk);
  endtask

  task automatic frame(input logic [6:0] d1, input logic [6:0] d2,
                       input logic [6:0] d3, input logic [6:0] d4);
    hold(PH_A, d1, d3, STABLE);
    hold(PH_B, d2, d4, STABLE);
    hold(PH_BL, DARK, DARK, 2);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    hold(PH_BL, DARK, DARK, 3);
    @(negedge clk);
    n_cmp++; if (value !== 10'd0)    begin n_err++; $display("FAIL reset_value: got %0d, required 0", value); end
    n_cmp++; if (value_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", value_valid); end
    n_cmp++; if (dash_err !== 1'b0)  begin n_err++; $display("FAIL reset_dash: got %b, required 0", dash_err); end
    n_cmp++; if (code_err !== 1'b0)  begin n_err++; $display("FAIL reset_code: got %b, required 0", code_err); end
    n_cmp++; if (timeout !== 1'b0)   begin n_err++; $display("FAIL reset_timeout: got %b, required 0", timeout); end
    n_cmp++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d, required 0", state_dbg); end
    rst_n = 1'b1;
  endtask

  task automatic test_frame_1023;
    exp_q.push_back({K_VALID, 10'd1023});
    hold(PH_A, seg_tab[1], seg_tab[2], STABLE);
    hold(PH_B, seg_tab[0], seg_tab[3], STABLE);
    @(negedge clk);
    power13 = 1'b0; power24 = 1'b0; seg_in = '0;
    // count reaches STABLE on the next edge; valid is due two edges later
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (value_valid !== (i == 2)) begin
        n_err++;
        $display("FAIL latency_%0d: value_valid got %b, required %b", i, value_valid, (i == 2));
      end
    end
    wait_drain(10);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL drain_1023: pending %0d, required 0", exp_q.size()); exp_q.delete(); end
    n_cmp++; if (value !== 10'd1023) begin n_err++; $display("FAIL value_1023: got %0d, required 1023", value); end
    last_good = 10'd1023;
  endtask

  task automatic test_reset_mid_wait_b;
    hold(PH_A, seg_tab[1], seg_tab[2], STABLE);
    hold(PH_BL, DARK, DARK, 3);
    @(negedge clk);
    n_cmp++; if (state_dbg !== 2'd1) begin n_err++; $display("FAIL wait_b_entry: state got %0d, required 1", state_dbg); end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (value !== 10'd0)    begin n_err++; $display("FAIL midreset_value: got %0d, required 0", value); end
    n_cmp++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL midreset_state: got %0d, required 0", state_dbg); end
    n_cmp++; if ({value_valid, dash_err, code_err, timeout} !== 4'b0) begin
      n_err++; $display("FAIL midreset_pulses: got %b, required 0000", {value_valid, dash_err, code_err, timeout});
    end
    rst_n = 1'b1;
    last_good = 10'd0;
    // B alone must not complete a frame after reset
    hold(PH_B, seg_tab[0], seg_tab[3], STABLE + 2);
    hold(PH_BL, DARK, DARK, 6);
    n_cmp++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL b_only_state: got %0d, required 0", state_dbg); end
  endtask

  task automatic test_glitch;
    // A held one cycle short is never accepted, so B alone does nothing
    hold(PH_A, DARK, seg_tab[8], STABLE - 1);
    hold(PH_B, seg_tab[5], seg_tab[7], STABLE);
    hold(PH_BL, DARK, DARK, 6);
    n_cmp++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL short_hold_state: got %0d, required 0", state_dbg); end
    // 3-cycle hold, one segment toggles, then a full hold
    exp_q.push_back({K_VALID, 10'd597});
    hold(PH_A, DARK, seg_tab[8], STABLE - 1);
    hold(PH_A, DARK, seg_tab[9], STABLE);
    hold(PH_B, seg_tab[5], seg_tab[7], STABLE);
    hold(PH_BL, DARK, DARK, 2);
    wait_drain(10);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL drain_glitch: pending %0d, required 0", exp_q.size()); exp_q.delete(); end
    last_good = 10'd597;
  endtask

  task automatic test_range;
    exp_q.push_back({K_CODE, last_good});
    frame(seg_tab[1], seg_tab[5], seg_tab[0], seg_tab[0]);
    wait_drain(10);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL drain_range: pending %0d, required 0", exp_q.size()); exp_q.delete(); end
    n_cmp++; if (value !== last_good) begin n_err++; $display("FAIL range_hold: got %0d, required %0d", value, last_good); end
  endtask

  task automatic test_error_frames;
    exp_q.push_back({K_DASH, last_good});
    frame(DASH, DASH, DASH, DASH);
    exp_q.push_back({K_CODE, last_good});
    frame(DASH, DASH, DASH, seg_tab[0]);
    exp_q.push_back({K_CODE, last_good});
    frame(seg_tab[0], seg_tab[1], ILL, seg_tab[2]);
    wait_drain(10);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL drain_errors: pending %0d, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_blank_digits;
    exp_q.push_back({K_VALID, 10'd42});
    frame(DARK, DARK, seg_tab[4], seg_tab[2]);
    exp_q.push_back({K_VALID, 10'd0});
    frame(DARK, DARK, DARK, DARK);
    wait_drain(10);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL drain_blank: pending %0d, required 0", exp_q.size()); exp_q.delete(); end
    last_good = 10'd0;
  endtask

  task automatic test_random_frames;
    for (int i = 0; i < 12; i++) begin
      int a, b, c, d, v;
      a = $urandom_range(0, 1);
      b = $urandom_range(0, 9);
      c = $urandom_range(0, 9);
      d = $urandom_range(0, 9);
      v = a * 1000 + b * 100 + c * 10 + d;
      if (v > 1023) begin
        exp_q.push_back({K_CODE, last_good});
      end else begin
        last_good = v[9:0];
        exp_q.push_back({K_VALID, last_good});
      end
      frame(seg_tab[a], seg_tab[b], seg_tab[c], seg_tab[d]);
    end
    wait_drain(10);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL drain_random: pending %0d, required 0", exp_q.size()); exp_q.delete(); end
    n_cmp++; if (value !== last_good) begin n_err++; $display("FAIL random_value: got %0d, required %0d", value, last_good); end
  endtask

  task automatic test_back_to_back;
    exp_q.push_back({K_VALID, 10'd815});
    exp_q.push_back({K_VALID, 10'd815});
    frame(DARK, seg_tab[8], seg_tab[1], seg_tab[5]);
    frame(DARK, seg_tab[8], seg_tab[1], seg_tab[5]);
    wait_drain(10);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL drain_b2b: pending %0d, required 0", exp_q.size()); exp_q.delete(); end
    last_good = 10'd815;
  endtask

  task automatic test_timeout;
    int k = 0;
    exp_q.push_back({K_TOUT, last_good});
    hold(PH_A, seg_tab[1], seg_tab[2], STABLE);
    @(negedge clk);
    power13 = 1'b0; power24 = 1'b0; seg_in = '0;
    while (timeout !== 1'b1 && k < TOUT + 20) begin
      @(negedge clk);
      k++;
    end
    // accept edge, WAIT_B entry edge, then TOUT cycles in WAIT_B
    n_cmp++; if (k != TOUT + 2) begin n_err++; $display("FAIL timeout_cycle: pulse after %0d cycles, required %0d", k, TOUT + 2); end
    @(negedge clk);
    n_cmp++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL timeout_state: got %0d, required 0", state_dbg); end
    hold(PH_B, seg_tab[0], seg_tab[3], STABLE + 2);
    hold(PH_BL, DARK, DARK, 6);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL drain_timeout: pending %0d, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_long_hold;
    // A held far past STABLE is accepted once, so the window still expires
    exp_q.push_back({K_TOUT, last_good});
    hold(PH_A, seg_tab[1], seg_tab[2], TOUT + 12);
    hold(PH_B, seg_tab[0], seg_tab[3], STABLE + 2);
    hold(PH_BL, DARK, DARK, 6);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL drain_long: pending %0d, required 0", exp_q.size()); exp_q.delete(); end
    n_cmp++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL long_state: got %0d, required 0", state_dbg); end
  endtask

  initial begin
    seg_tab[0] = 7'b0111111; seg_tab[1] = 7'b0000110; seg_tab[2] = 7'b1011011;
    seg_tab[3] = 7'b1001111; seg_tab[4] = 7'b1100110; seg_tab[5] = 7'b1101101;
    seg_tab[6] = 7'b1111101; seg_tab[7] = 7'b0000111; seg_tab[8] = 7'b1111111;
    seg_tab[9] = 7'b1101111;
    rst_n   = 1'b0;
    seg_in  = '0;
    power13 = 1'b0;
    power24 = 1'b0;

    test_reset;
    test_frame_1023;
    test_reset_mid_wait_b;
    test_glitch;
    test_range;
    test_error_frames;
    test_blank_digits;
    test_random_frames;
    test_back_to_back;
    test_timeout;
    test_long_hold;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
